param_array_rr_mux: RTL and testbench
=====================================

// Module: param_array_rr_mux
// PURPOSE
//  Parametrised N-channel stream concentrator. All per-channel ports are unpacked arrays sized by NCH.
//  Round-robin arbiter selects one valid channel per cycle into a single registered output stage
//  with valid/ready handshake. Keeps per-channel saturating grant counters for debug/perf readout.
//  Sits between parallel producer lanes and a single downstream consumer.
// PARAMETERS
//  NCH  6   number of input channels (>=1, need not be a power of two)
//  DW   8   payload width per channel
//  CW   16  grant-counter width per channel
//  IDW  localparam = (NCH>1) ? $clog2(NCH) : 1, channel-id width
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous reset, active low
//  in_valid   in   1 [NCH]        per-channel valid (unpacked array)
//  in_data    in   [DW-1:0] [NCH] per-channel payload (unpacked array)
//  in_ready   out  1 [NCH]        per-channel ready (unpacked array)
//  out_valid  out  1              output register holds a beat
//  out_data   out  DW             payload of held beat
//  out_ch     out  IDW            source channel of held beat
//  out_ready  in   1              downstream accept
//  clr_cnt    in   1              synchronous clear of all grant counters
//  grant_cnt  out  [CW-1:0] [NCH] per-channel accepted-beat count (unpacked array)
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n is asynchronous, active low.
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, ptr=0, grant_cnt[*]=0.
//  Output stage FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//   load_en = !out_valid || out_ready.
//   EMPTY: any in_valid -> load, go FULL; else stay EMPTY.
//   FULL: out_ready=0 -> hold out_data/out_ch bit-stable, all in_ready=0.
//         out_ready=1 and some in_valid -> reload same cycle, stay FULL (full throughput).
//         out_ready=1 and no in_valid -> EMPTY.
//  Arbitration: grant = first i with in_valid[i], scanning ptr, ptr+1, ... NCH-1, 0, ... ptr-1.
//   in_ready[i] = load_en && (grant==i) && in_valid[i]; at most one in_ready high per cycle.
//   in_ready depends combinationally on out_ready; there is no comb path from in_* to out_valid.
//   Transfer on channel i when in_valid[i] && in_ready[i]; then ptr <= (i==NCH-1) ? 0 : i+1.
//   No transfer -> ptr unchanged. Non-power-of-two NCH: ptr never takes values >= NCH.
//  Latency: accepted beat appears on out_* the next cycle; one beat per cycle sustained.
//  Producers must hold in_valid/in_data until in_ready; the block does not buffer unaccepted beats.
//  grant_cnt[i]: +1 per transfer on channel i, saturates at 2^CW-1 (no wrap).
//   clr_cnt=1 forces all counters to 0 that cycle; clear wins over a simultaneous increment.
//  NCH=1: arbiter degenerates, out_ch always 0, ptr constant 0.
//  Reset mid-transfer: held beat is discarded, out_valid drops immediately (async), no partial state.
// TESTING
//  T1 NCH=6, all in_valid=1, out_ready=1 -> out_ch 0,1,2,3,4,5,0 on consecutive cycles; grant_cnt[*]=1 after 6 beats.
//  T2 beat from ch2 data 8'hA5 held, out_ready=0 for 3 cycles -> out_data=8'hA5/out_ch=2 stable, in_ready all 0.
//  T3 ptr=2, only ch5 and ch1 valid -> grants ch5, then ch1, then ch5 (wrap through 0).
//  T4 CW=4, ch0 valid for 20 beats -> grant_cnt[0] reaches 15 and holds; clr_cnt with same-cycle grant -> 0.
//  T5 rst_n low while FULL with out_ready=0 -> out_valid=0, counters 0 same cycle; after release ptr=0, ch0 first.
//  T6 NCH=1, DW=32: stream 4 beats with random out_ready -> out_ch always 0, data order preserved, no drops.

Source files
------------

// File: rtl/param_array_rr_mux.sv
// -----------------------------------------------------------------------------
// param_array_rr_mux
//   N-channel stream concentrator. A round-robin arbiter picks one valid input
//   channel per cycle and loads it into a single registered output stage with a
//   valid/ready handshake. Per-channel saturating grant counters count accepted
//   beats for debug/performance readout.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   [NCH]          per-channel valid
//   in_data    [NCH][DW]      per-channel payload
//   in_ready   [NCH]          per-channel ready (at most one high per cycle)
//   out_valid                 output register holds a beat
//   out_data   [DW]           payload of the held beat
//   out_ch     [IDW]          source channel of the held beat
//   out_ready                 downstream accept
//   clr_cnt                   synchronous clear of all grant counters
//   grant_cnt  [NCH][CW]      per-channel accepted-beat count, saturating
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high. Producers hold valid/data stable until ready; ready may
// depend combinationally on valid (in_ready also follows out_ready), while
// out_valid is purely registered.
// -----------------------------------------------------------------------------
module param_array_rr_mux #(
    parameter int NCH = 6,
    parameter int DW  = 8,
    parameter int CW  = 16,
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid  [NCH],
    input  logic [DW-1:0]  in_data   [NCH],
    output logic           in_ready  [NCH],
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    output logic [IDW-1:0] out_ch,
    input  logic           out_ready,
    input  logic           clr_cnt,
    output logic [CW-1:0]  grant_cnt [NCH]
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;
    logic           hi_found;
    logic           any_valid;
    logic           load_en;
    logic           transfer;
    logic [DW-1:0]  sel_data;

    // The output register may take a new beat when it is empty or being drained.
    assign load_en   = (state == EMPTY) || out_ready;
    assign transfer  = load_en && any_valid;
    assign out_valid = (state == FULL);

    // Rotating priority without a modulo: the lowest valid index at or above
    // ptr wins; if there is none, the lowest valid index overall wins (wrap).
    // Descending loops leave the smallest matching index in hi_idx / lo_idx.
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        any_valid = 1'b0;
        lo_idx    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                any_valid = 1'b1;
                lo_idx    = IDW'(i);
                if (IDW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = load_en && (grant == IDW'(i)) && in_valid[i];
            if (grant == IDW'(i)) begin
                sel_data = in_data[i];
            end
        end
    end

    // Pointer moves to the channel after the winner, wrapping explicitly so a
    // non-power-of-two NCH never leaves ptr at an unused code.
    always_comb begin
        ptr_nxt = ptr;
        if (transfer) begin
            if (grant == IDW'(NCH - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = grant + IDW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_en) begin
            state_nxt = any_valid ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_ch   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (transfer) begin
                out_data <= sel_data;
                out_ch   <= grant;
            end
        end
    end

    // Clear has priority over a same-cycle increment; increments stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr_cnt) begin
                    grant_cnt[i] <= '0;
                end else if (transfer && (grant == IDW'(i)) &&
                             (grant_cnt[i] != {CW{1'b1}})) begin
                    grant_cnt[i] <= grant_cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_param_array_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_param_array_rr_mux
//   Three instances: the default 6-channel block (scoreboard plus directed
//   cases), a CW=4 copy for counter saturation, and an NCH=1/DW=32 copy for the
//   degenerate single-channel case.
// -----------------------------------------------------------------------------
module tb_param_array_rr_mux;

    localparam int NCH = 6;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int IDW = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance ----------------
    logic           m_in_valid  [NCH];
    logic [DW-1:0]  m_in_data   [NCH];
    logic           m_in_ready  [NCH];
    logic           m_out_valid;
    logic [DW-1:0]  m_out_data;
    logic [IDW-1:0] m_out_ch;
    logic           m_out_ready;
    logic           m_clr;
    logic [CW-1:0]  m_cnt       [NCH];

    param_array_rr_mux #(.NCH(NCH), .DW(DW), .CW(CW)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_data(m_in_data), .in_ready(m_in_ready),
        .out_valid(m_out_valid), .out_data(m_out_data), .out_ch(m_out_ch),
        .out_ready(m_out_ready), .clr_cnt(m_clr), .grant_cnt(m_cnt)
    );

    // ---------------- saturation instance (CW=4) ----------------
    logic           s_in_valid  [NCH];
    logic [DW-1:0]  s_in_data   [NCH];
    logic           s_in_ready  [NCH];
    logic           s_out_valid;
    logic [DW-1:0]  s_out_data;
    logic [IDW-1:0] s_out_ch;
    logic           s_out_ready;
    logic           s_clr;
    logic [3:0]     s_cnt       [NCH];

    param_array_rr_mux #(.NCH(NCH), .DW(DW), .CW(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ch(s_out_ch),
        .out_ready(s_out_ready), .clr_cnt(s_clr), .grant_cnt(s_cnt)
    );

    // ---------------- single-channel instance ----------------
    logic        o_in_valid [1];
    logic [31:0] o_in_data  [1];
    logic        o_in_ready [1];
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic [0:0]  o_out_ch;
    logic        o_out_ready;
    logic        o_clr;
    logic [15:0] o_cnt      [1];

    param_array_rr_mux #(.NCH(1), .DW(32), .CW(16)) u_one (
        .clk(clk), .rst_n(rst_n),
        .in_valid(o_in_valid), .in_data(o_in_data), .in_ready(o_in_ready),
        .out_valid(o_out_valid), .out_data(o_out_data), .out_ch(o_out_ch),
        .out_ready(o_out_ready), .clr_cnt(o_clr), .grant_cnt(o_cnt)
    );

    // ---------------- bench model state (main instance) ----------------
    logic            pend [NCH];   // producer holds a beat on this channel
    logic [DW-1:0]   pdat [NCH];
    logic            md_valid;
    int              md_ptr;
    int              md_cnt [NCH];
    logic [IDW+DW-1:0] exp_q [$];
    logic [31:0]     one_q [$];

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        md_valid = 1'b0;
        md_ptr   = 0;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) begin
            md_cnt[i] = 0;
            pend[i]   = 1'b0;
            pdat[i]   = '0;
        end
    endtask

    task automatic idle_inputs();
        m_out_ready = 1'b0;
        m_clr       = 1'b0;
        s_out_ready = 1'b0;
        s_clr       = 1'b0;
        o_out_ready = 1'b0;
        o_clr       = 1'b0;
        o_in_valid[0] = 1'b0;
        o_in_data[0]  = '0;
        for (int i = 0; i < NCH; i++) begin
            m_in_valid[i] = 1'b0;
            m_in_data[i]  = '0;
            s_in_valid[i] = 1'b0;
            s_in_data[i]  = '0;
        end
    endtask

    // Leaves the bench on a falling edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle of the main instance: drive producer state, compare outputs and
    // handshake against the model, advance the model across the coming edge.
    task automatic step(output int g);
        logic             load;
        logic [NCH-1:0]   rdy_obs;
        logic [NCH-1:0]   rdy_exp;
        int               idx;
        for (int i = 0; i < NCH; i++) begin
            m_in_valid[i] = pend[i];
            m_in_data[i]  = pdat[i];
        end
        #1;
        check("out_valid", m_out_valid, md_valid);
        for (int i = 0; i < NCH; i++) begin
            check("grant_cnt", m_cnt[i], md_cnt[i]);
        end
        if (md_valid && m_out_ready) begin
            if (exp_q.size() == 0) check("beat_q_size", exp_q.size(), 1);
            else check("beat", {m_out_ch, m_out_data}, exp_q.pop_front());
        end
        load = !md_valid || m_out_ready;
        g = -1;
        if (load) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (md_ptr + k) % NCH;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            rdy_obs[i] = m_in_ready[i];
            rdy_exp[i] = (i == g);
        end
        check("in_ready", rdy_obs, rdy_exp);
        if (load) md_valid = (g >= 0);
        if (g >= 0) begin
            exp_q.push_back({IDW'(g), pdat[g]});
            md_ptr  = (g + 1) % NCH;
            pend[g] = 1'b0;
            if (md_cnt[g] < (2 ** CW) - 1) md_cnt[g]++;
        end
        if (m_clr) begin
            for (int i = 0; i < NCH; i++) md_cnt[i] = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int  g;
        int  n;
        logic busy;
        m_out_ready = 1'b1;
        m_clr       = 1'b0;
        n = 0;
        busy = 1'b1;
        while (busy && n < 100) begin
            step(g);
            n++;
            busy = md_valid;
            for (int i = 0; i < NCH; i++) busy = busy | pend[i];
        end
        check("drain_busy", busy, 0);
        check("drain_q_size", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int g;
        logic [NCH-1:0] rv;
        int sent;
        int recv;
        int n;
        logic acc;

        do_reset();
        #1;
        check("rst_out_valid", m_out_valid, 0);
        check("rst_out_data", m_out_data, 0);
        check("rst_out_ch", m_out_ch, 0);
        check("rst_sat_valid", s_out_valid, 0);
        check("rst_one_valid", o_out_valid, 0);
        @(negedge clk);

        // T1: all channels valid, full throughput, strict rotation.
        m_out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = 1'b1;
            pdat[i] = DW'(8'h10 + i);
        end
        for (int k = 0; k < 7; k++) begin
            step(g);
            if (g >= 0) begin
                pend[g] = 1'b1;
                pdat[g] = DW'($urandom_range(0, 255));
            end
            check("t1_ch", m_out_ch, k % 6);
            if (k == 5) begin
                for (int i = 0; i < NCH; i++) check("t1_cnt", m_cnt[i], 1);
            end
        end
        for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
        drain();

        // T2: held beat stays bit-stable under backpressure.
        do_reset();
        m_out_ready = 1'b1;
        pend[2] = 1'b1;
        pdat[2] = 8'hA5;
        step(g);
        m_out_ready = 1'b0;
        pend[0] = 1'b1; pdat[0] = 8'h11;
        pend[4] = 1'b1; pdat[4] = 8'h44;
        for (int k = 0; k < 3; k++) begin
            step(g);
            check("t2_data", m_out_data, 8'hA5);
            check("t2_ch", m_out_ch, 2);
            for (int i = 0; i < NCH; i++) rv[i] = m_in_ready[i];
            check("t2_ready", rv, 0);
        end
        drain();

        // T3: ptr=2 with only ch5 and ch1 valid -> 5, 1, 5.
        do_reset();
        m_out_ready = 1'b1;
        pend[1] = 1'b1; pdat[1] = 8'h21;
        step(g);
        check("t3_first", m_out_ch, 1);
        pend[1] = 1'b1; pdat[1] = 8'h22;
        pend[5] = 1'b1; pdat[5] = 8'h51;
        step(g);
        check("t3_a", m_out_ch, 5);
        pend[5] = 1'b1; pdat[5] = 8'h52;
        step(g);
        check("t3_b", m_out_ch, 1);
        step(g);
        check("t3_c", m_out_ch, 5);
        check("t3_c_data", m_out_data, 8'h52);
        drain();

        // T4: saturation at 15 and clear beating a same-cycle grant.
        do_reset();
        s_in_valid[0] = 1'b1;
        s_in_data[0]  = 8'h3C;
        s_out_ready   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("t4_cnt", s_cnt[0], (k < 15) ? k : 15);
            check("t4_ch", s_out_ch, 0);
        end
        s_clr = 1'b1;
        @(negedge clk);
        check("t4_clr", s_cnt[0], 0);
        s_clr = 1'b0;
        @(negedge clk);
        check("t4_after_clr", s_cnt[0], 1);
        s_in_valid[0] = 1'b0;
        s_out_ready   = 1'b0;

        // T5: async reset while FULL and stalled.
        do_reset();
        m_out_ready = 1'b1;
        pend[3] = 1'b1; pdat[3] = 8'h33;
        step(g);
        m_out_ready = 1'b0;
        step(g);
        check("t5_pre_valid", m_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", m_out_valid, 0);
        check("t5_data", m_out_data, 0);
        check("t5_cnt", m_cnt[3], 0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        m_out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = 1'b1;
            pdat[i] = DW'(8'h60 + i);
        end
        step(g);
        check("t5_first_ch", m_out_ch, 0);
        drain();

        // Random traffic against the scoreboard, including random clears.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdat[i] = DW'($urandom_range(0, 255));
                end
            end
            m_out_ready = ($urandom_range(0, 3) != 0);
            m_clr       = ($urandom_range(0, 31) == 0);
            step(g);
        end
        drain();

        // T6: single channel, random backpressure, order preserved.
        do_reset();
        one_q.delete();
        sent = 0;
        recv = 0;
        n = 0;
        while (recv < 4 && n < 200) begin
            if (!o_in_valid[0] && sent < 4) begin
                o_in_valid[0] = 1'b1;
                o_in_data[0]  = $urandom;
            end
            o_out_ready = 1'($urandom_range(0, 1));
            #1;
            if (o_out_valid && o_out_ready) begin
                check("t6_ch", o_out_ch, 0);
                if (one_q.size() == 0) check("t6_q_size", one_q.size(), 1);
                else check("t6_data", o_out_data, one_q.pop_front());
                recv++;
            end
            acc = o_in_valid[0] && o_in_ready[0];
            if (acc) begin
                one_q.push_back(o_in_data[0]);
                sent++;
            end
            @(negedge clk);
            if (acc) o_in_valid[0] = 1'b0;
            n++;
        end
        check("t6_recv", recv, 4);
        check("t6_cnt", o_cnt[0], 4);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
